// File: rtl/pcileech_tlp_rx_packer.sv
// pcileech_tlp_rx_packer: packs the RX TLP DWORD stream into 8-DWORD blocks
// (7 data slots + 1 status DWORD) for the FT601 transmit path. There are two
// block buffers, so one can fill while the other drains.
// Optional build macro RX_PACKER_TIMEOUT_FLUSH_EN: a partial block closes
// after FLUSH_TIMEOUT idle cycles.
module pcileech_tlp_rx_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 64,
  parameter logic [3:0]  STATUS_MAGIC  = 4'hE
) (
  input  logic        clk_100,
  input  logic        rst,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  input  logic        in_flush,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sob
);

  typedef enum logic {IDLE, SEND} state_t;

  logic [1:0][6:0][31:0] buf_data;
  logic [1:0][6:0]       buf_vld;
  logic [1:0][6:0]       buf_lst;
  logic [1:0]            full;
  logic                  fill_ptr, drain_ptr;
  logic [2:0]            fill_cnt, cnt_nx;
  logic                  inflight;
  logic                  wr, flush_req, close, drain_done, tmo_hit;
  state_t                state;
  logic [2:0]            slot;

  // Fill-side decode. A flush request holds off new reads, so a close never
  // leaves a word in flight. Any word landing in the same cycle is counted
  // into the block that closes.
  assign wr        = inflight & in_valid;
  assign cnt_nx    = fill_cnt + {2'b0, wr};
  assign flush_req = in_flush | tmo_hit;
  assign close     = (cnt_nx == 3'd7) | (flush_req & (cnt_nx != 3'd0));
  assign in_rd_en  = ~rst & ~in_empty & ~full[fill_ptr] & ~flush_req &
                     (({1'b0, fill_cnt} + {3'b0, inflight}) < 4'd7);
  assign drain_done = (state == SEND) & (slot == 3'd7) & out_valid & out_ready;

`ifdef RX_PACKER_TIMEOUT_FLUSH_EN
  logic [15:0] idle_cnt;
  logic        idle_tick;
  assign idle_tick = (fill_cnt != 3'd0) & ~inflight;
  assign tmo_hit   = idle_tick & (idle_cnt == 16'(FLUSH_TIMEOUT - 1));

  // Idle counter: counts quiet cycles on a partial block and restarts on any returned word
  always_ff @(posedge clk_100) begin
    if (rst || inflight || close) idle_cnt <= '0;
    else if (idle_tick)           idle_cnt <= idle_cnt + 16'd1;
  end
`else
  // No timeout path in this build; the parameter only keeps the instance interface uniform
  assign tmo_hit = (FLUSH_TIMEOUT == 0) & 1'b0;
`endif

  // Word emitted for a given buffer and slot: data (0 if the slot is empty), or status in slot 7
  function automatic logic [31:0] slot_word(input logic b, input logic [2:0] s);
    logic [31:0] w;
    w = '0;
    if (s == 3'd7) begin
      w[31:28] = STATUS_MAGIC;
      for (int i = 0; i < 7; i++) begin
        w[2*i]   = buf_vld[b][i];
        w[2*i+1] = buf_lst[b][i];
      end
    end else if (buf_vld[b][s]) begin
      w = buf_data[b][s];
    end
    return w;
  endfunction

  // Fill side: write the returned words, close blocks, and release blocks that have drained
  always_ff @(posedge clk_100) begin
    if (rst) begin
      full     <= '0;
      buf_vld  <= '0;
      buf_lst  <= '0;
      fill_ptr <= 1'b0;
      fill_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= in_rd_en;
      if (drain_done) begin
        full[drain_ptr]    <= 1'b0;
        buf_vld[drain_ptr] <= '0;
        buf_lst[drain_ptr] <= '0;
      end
      if (wr) begin
        buf_data[fill_ptr][fill_cnt] <= in_data;
        buf_vld[fill_ptr][fill_cnt]  <= 1'b1;
        buf_lst[fill_ptr][fill_cnt]  <= in_last;
      end
      if (close) begin
        full[fill_ptr] <= 1'b1;
        fill_ptr       <= ~fill_ptr;
        fill_cnt       <= '0;
      end else begin
        fill_cnt <= cnt_nx;
      end
    end
  end

  // Drain FSM: emit 8 registered words per full buffer, chaining blocks with no gap between them
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      drain_ptr <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sob   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full[drain_ptr]) begin
            state     <= SEND;
            slot      <= '0;
            out_data  <= slot_word(drain_ptr, 3'd0);
            out_valid <= 1'b1;
            out_sob   <= 1'b1;
          end
        end
        SEND: begin
          if (out_valid && out_ready) begin
            if (slot == 3'd7) begin
              drain_ptr <= ~drain_ptr;
              if (full[~drain_ptr]) begin
                slot     <= '0;
                out_data <= slot_word(~drain_ptr, 3'd0);
                out_sob  <= 1'b1;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_sob   <= 1'b0;
                out_data  <= '0;
              end
            end else begin
              slot     <= slot + 3'd1;
              out_data <= slot_word(drain_ptr, slot + 3'd1);
              out_sob  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_tlp_rx_packer.sv
// Bench for pcileech_tlp_rx_packer. A queue models the RX FIFO, and a
// block-level reference model groups valid words into 7-slot blocks. The
// expected words go into a scoreboard that the output monitor pops.
module tb_pcileech_tlp_rx_packer;
  localparam logic [3:0] MAGIC = 4'hE;

  logic        clk_100 = 1'b0, rst = 1'b1;
  logic        in_rd_en, in_empty = 1'b1, in_last = 1'b0, in_valid = 1'b0, in_flush = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] out_data;
  logic        out_valid, out_ready = 1'b1, out_sob;

  pcileech_tlp_rx_packer dut (
    .clk_100(clk_100), .rst(rst), .in_rd_en(in_rd_en), .in_empty(in_empty),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_flush(in_flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sob(out_sob));

  always #5 clk_100 = ~clk_100;

  typedef struct { logic [31:0] d; logic l; logic v; } ent_t;
  typedef struct { logic [31:0] d; logic sob; } exp_t;
  ent_t fifo_q[$];
  ent_t part_q[$];
  exp_t exp_q[$];
  int   tests = 0, fails = 0, n_out = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is the valid words in arrival order, zero padded, followed by status
  function automatic void emit_block();
    logic [31:0] st;
    int n;
    n  = part_q.size();
    st = {MAGIC, 28'h0};
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      e.sob = (i == 0);
      e.d   = 32'h0;
      if (i < n) begin
        e.d        = part_q[i].d;
        st[2*i]    = 1'b1;
        st[2*i+1]  = part_q[i].l;
      end
      exp_q.push_back(e);
    end
    begin
      exp_t s;
      s.d = st; s.sob = 1'b0;
      exp_q.push_back(s);
    end
    part_q.delete();
  endfunction

  function automatic void push_word(input logic [31:0] d, input logic l, input logic v);
    ent_t e;
    e.d = d; e.l = l; e.v = v;
    fifo_q.push_back(e);
    if (v) begin
      part_q.push_back(e);
      if (part_q.size() == 7) emit_block();
    end
  endfunction

  function automatic void model_flush();
    if (part_q.size() > 0) emit_block();
  endfunction

  task automatic tick();
    @(posedge clk_100); #1;
  endtask

  // RX FIFO model: a read strobe returns the head entry during the next cycle; otherwise the bus carries junk marked valid
  logic rd;
  always begin
    @(negedge clk_100);
    rd = in_rd_en;
    if (rd && fifo_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL rd_on_empty: got in_rd_en=1 expected 0 at %0t", $time);
    end
    @(posedge clk_100); #1;
    if (rd && fifo_q.size() > 0) begin
      ent_t e;
      e = fifo_q.pop_front();
      in_data = e.d; in_last = e.l; in_valid = e.v;
    end else begin
      in_data = $urandom; in_last = 1'($urandom); in_valid = 1'b1;
    end
    #1 in_empty = (fifo_q.size() == 0);
  end

  // Random backpressure while enabled
  always begin
    @(posedge clk_100); #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: scoreboard compare on each accept, plus hold check while stalled
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  exp_t        me;
  always @(negedge clk_100) begin
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_data", out_data, prev_data);
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got %h expected no output at %0t", out_data, $time);
        end else begin
          me = exp_q.pop_front();
          chk("out_data", out_data, me.d);
          chk("out_sob", {31'b0, out_sob}, {31'b0, me.sob});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < 3000) begin tick(); k++; end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_landed();
    int k = 0;
    while (fifo_q.size() != 0 && k < 3000) begin tick(); k++; end
    chk("fifo_timeout", fifo_q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic do_flush();
    wait_landed();
    in_flush = 1'b1;
    model_flush();
    tick();
    in_flush = 1'b0;
  endtask

  initial begin
    int n0, k;
    repeat (3) tick();
    // reset state, with a word already waiting in the FIFO
    push_word(32'h1, 1'b0, 1'b1);
    repeat (2) tick();
    @(negedge clk_100);
    chk("rst_rd_en", {31'b0, in_rd_en}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sob", {31'b0, out_sob}, 32'd0);
    tick();
    rst = 1'b0;
    // one full block 1..7, last on 7
    for (int i = 2; i <= 7; i++) push_word(32'(i), (i == 7), 1'b1);
    wait_drain();

    // 14 back-to-back words: the second block follows the first status with no gap
    for (int i = 0; i < 14; i++) push_word($urandom, (i % 5 == 4), 1'b1);
    k = 0;
    @(negedge clk_100);
    while (!(out_valid && out_sob) && k < 200) begin @(negedge clk_100); k++; end
    chk("first_sob", {31'b0, out_sob}, 32'd1);
    repeat (15) begin @(negedge clk_100); chk("nogap", {31'b0, out_valid}, 32'd1); end
    wait_drain();

    // partial block of 3 words closed by a flush
    for (int i = 0; i < 3; i++) push_word(32'hA000 + 32'(i), (i == 2), 1'b1);
    do_flush();
    wait_drain();

    // a flush with an empty buffer produces nothing
    n0 = n_out;
    in_flush = 1'b1; tick(); in_flush = 1'b0;
    repeat (30) tick();
    chk("empty_flush", n_out, n0);

    // backpressure: both buffers fill, then reads stop
    out_ready = 1'b0;
    for (int i = 0; i < 21; i++) push_word($urandom, 1'($urandom), 1'b1);
    repeat (40) tick();
    @(negedge clk_100);
    chk("stall_rd_en", {31'b0, in_rd_en}, 32'd0);
    chk("stall_fifo_left", fifo_q.size(), 7);
    tick();
    out_ready = 1'b1;
    wait_drain();

    // discarded entries consume no slot
    for (int i = 0; i < 12; i++) push_word($urandom, 1'($urandom), 1'(i % 3 != 1));
    do_flush();
    wait_drain();

    // reset mid-block discards the partial data
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 1'b1);
    wait_landed();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    part_q.delete();
    for (int i = 0; i < 7; i++) push_word(32'hB000 + 32'(i), (i == 6), 1'b1);
    wait_drain();

    // two words followed by a long idle period
    push_word(32'hC001, 1'b0, 1'b1);
    push_word(32'hC002, 1'b1, 1'b1);
    wait_landed();
    n0 = n_out;
`ifdef RX_PACKER_TIMEOUT_FLUSH_EN
    model_flush();
`endif
    repeat (1000) tick();
`ifdef RX_PACKER_TIMEOUT_FLUSH_EN
    chk("idle_timeout_out", n_out, n0 + 8);
`else
    chk("idle_no_out", n_out, n0);
`endif
    do_flush();
    wait_drain();

    // randomized bursts with backpressure and occasional flushes
    rnd_ready = 1;
    for (int it = 0; it < 40; it++) begin
      int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        push_word($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
      repeat ($urandom_range(0, 10)) tick();
      if ($urandom_range(0, 3) == 0) do_flush();
    end
    do_flush();
    wait_drain();
    rnd_ready = 0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("final_scoreboard", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
